regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
// Bundles the two writeback request ports, the write-enable gate, the
// registered register-file write port and the contention counter.
//   wb_enable            : grants permitted when 1
//   inN_valid/inN_ready  : port N handshake (N = 0 ALU, 1 load/multi-cycle)
//   inN_addr/inN_data    : port N destination register and value
//   rf_write/waddr/wdata : registered register-file write port
//   contention_cnt       : saturating count of cycles with a denied request
// Modports: master = requesters / register file side, slave = arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
);
    logic              wb_enable;
    logic              in0_valid;
    logic              in0_ready;
    logic [ADDR_W-1:0] in0_addr;
    logic [DATA_W-1:0] in0_data;
    logic              in1_valid;
    logic              in1_ready;
    logic [ADDR_W-1:0] in1_addr;
    logic [DATA_W-1:0] in1_data;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  contention_cnt;

    modport master (
        output wb_enable,
        output in0_valid, in0_addr, in0_data,
        output in1_valid, in1_addr, in1_data,
        input  in0_ready, in1_ready,
        input  rf_write, rf_waddr, rf_wdata,
        input  contention_cnt
    );

    modport slave (
        input  wb_enable,
        input  in0_valid, in0_addr, in0_data,
        input  in1_valid, in1_addr, in1_data,
        output in0_ready, in1_ready,
        output rf_write, rf_waddr, rf_wdata,
        output contention_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Two-port round-robin arbiter in front of a single register-file write
// port. A granted request is registered onto rf_* one cycle later; writes
// to register 0 are accepted but suppressed. Counts cycles in which an
// enabled, valid request was denied (saturating).
// Ports:
//   clk   : clock, rising-edge
//   reset : asynchronous, active-high reset
//   bus   : regfile_wb_arbiter_if.slave (handshakes, rf_* write port, counter)
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    typedef enum logic {
        LAST_P0 = 1'b0,
        LAST_P1 = 1'b1
    } last_e;

    last_e             last_q, last_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic grant0, grant1;
    logic xfer0, xfer1;
    logic denied;

    // Grant depends only on enable, valids and the pointer; on a tie the
    // port that was not granted last wins.
    always_comb begin
        grant0 = bus.wb_enable & bus.in0_valid &
                 (~bus.in1_valid | (last_q == LAST_P1));
        grant1 = bus.wb_enable & bus.in1_valid &
                 (~bus.in0_valid | (last_q == LAST_P0));
    end

    assign bus.in0_ready = grant0 & ~reset;
    assign bus.in1_ready = grant1 & ~reset;

    assign xfer0  = bus.in0_valid & bus.in0_ready;
    assign xfer1  = bus.in1_valid & bus.in1_ready;
    assign denied = bus.wb_enable &
                    ((bus.in0_valid & ~bus.in0_ready) |
                     (bus.in1_valid & ~bus.in1_ready));

    always_comb begin
        last_d     = last_q;
        rf_write_d = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        cnt_d      = cnt_q;

        // Address 0 transfers are consumed but leave rf_waddr/rf_wdata alone.
        if (xfer0) begin
            last_d = LAST_P0;
            if (bus.in0_addr != '0) begin
                rf_write_d = 1'b1;
                rf_waddr_d = bus.in0_addr;
                rf_wdata_d = bus.in0_data;
            end
        end else if (xfer1) begin
            last_d = LAST_P1;
            if (bus.in1_addr != '0) begin
                rf_write_d = 1'b1;
                rf_waddr_d = bus.in1_addr;
                rf_wdata_d = bus.in1_data;
            end
        end

        if (denied && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pointer resets to port 1 so port 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q     <= LAST_P1;
            rf_write_q <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            cnt_q      <= '0;
        end else begin
            last_q     <= last_d;
            rf_write_q <= rf_write_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.rf_write       = rf_write_q;
    assign bus.rf_waddr       = rf_waddr_q;
    assign bus.rf_wdata       = rf_wdata_q;
    assign bus.contention_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    logic clk;
    logic reset;
    int unsigned total;
    int unsigned bad;

    regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32), .CNT_W(8)) bus ();

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.in0_valid = v;
        bus.in0_addr  = a;
        bus.in0_data  = d;
    endtask

    task automatic set1(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.in1_valid = v;
        bus.in1_addr  = a;
        bus.in1_data  = d;
    endtask

    logic [31:0] d0, d1;
    logic        exp_p1;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.wb_enable = 1'b1;
        set0(1'b1, 5'd1, 32'h1);
        set1(1'b1, 5'd2, 32'h2);

        // Reset state; readies held low despite enabled valid requests
        #2;
        chk("rst_rf_write", bus.rf_write, 1'b0);
        chk("rst_waddr", bus.rf_waddr, 5'd0);
        chk("rst_wdata", bus.rf_wdata, 32'h0);
        chk("rst_cnt", bus.contention_cnt, 8'd0);
        chk("rst_ready0", bus.in0_ready, 1'b0);
        chk("rst_ready1", bus.in1_ready, 1'b0);
        tick();
        tick();
        chk("rst_hold_write", bus.rf_write, 1'b0);
        chk("rst_hold_cnt", bus.contention_cnt, 8'd0);

        // Single port-0 write, first edge after reset release
        set1(1'b0, 5'd0, 32'h0);
        set0(1'b1, 5'd5, 32'hDEADBEEF);
        reset = 1'b0;
        #1;
        chk("p0_only_ready0", bus.in0_ready, 1'b1);
        chk("p0_only_ready1", bus.in1_ready, 1'b0);
        tick();
        chk("p0_write", bus.rf_write, 1'b1);
        chk("p0_waddr", bus.rf_waddr, 5'd5);
        chk("p0_wdata", bus.rf_wdata, 32'hDEADBEEF);
        set0(1'b0, 5'd0, 32'h0);
        tick();
        chk("p0_idle_write", bus.rf_write, 1'b0);
        chk("p0_idle_waddr", bus.rf_waddr, 5'd5);
        chk("p0_idle_wdata", bus.rf_wdata, 32'hDEADBEEF);
        chk("p0_cnt", bus.contention_cnt, 8'd0);

        // Port-1 write to $zero accepted but suppressed
        set1(1'b1, 5'd0, 32'h1234);
        #1;
        chk("zero_ready1", bus.in1_ready, 1'b1);
        chk("zero_ready0", bus.in0_ready, 1'b0);
        tick();
        chk("zero_write", bus.rf_write, 1'b0);
        set1(1'b0, 5'd0, 32'h0);

        // Same address from both ports, pointer at 1: p0 first, then p1
        set0(1'b1, 5'd9, 32'h11);
        set1(1'b1, 5'd9, 32'h22);
        #1;
        chk("same_ready0", bus.in0_ready, 1'b1);
        chk("same_ready1", bus.in1_ready, 1'b0);
        tick();
        chk("same_w1_write", bus.rf_write, 1'b1);
        chk("same_w1_waddr", bus.rf_waddr, 5'd9);
        chk("same_w1_wdata", bus.rf_wdata, 32'h11);
        set0(1'b0, 5'd0, 32'h0);
        #1;
        chk("same_ready1_b", bus.in1_ready, 1'b1);
        tick();
        chk("same_w2_write", bus.rf_write, 1'b1);
        chk("same_w2_wdata", bus.rf_wdata, 32'h22);
        chk("same_cnt", bus.contention_cnt, 8'd1);
        set1(1'b0, 5'd0, 32'h0);

        // Enable gate low: nothing granted, nothing counted
        bus.wb_enable = 1'b0;
        set0(1'b1, 5'd4, 32'hA);
        set1(1'b1, 5'd6, 32'hB);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dis_ready0", bus.in0_ready, 1'b0);
            chk("dis_ready1", bus.in1_ready, 1'b0);
            tick();
            chk("dis_write", bus.rf_write, 1'b0);
            chk("dis_cnt", bus.contention_cnt, 8'd1);
        end
        bus.wb_enable = 1'b1;
        #1;
        chk("en_ready0", bus.in0_ready, 1'b1);
        chk("en_ready1", bus.in1_ready, 1'b0);
        tick();
        chk("en_waddr", bus.rf_waddr, 5'd4);
        chk("en_cnt", bus.contention_cnt, 8'd2);
        set0(1'b0, 5'd0, 32'h0);

        // Reset between the grant edge and the following edge
        #1;
        chk("mid_ready1", bus.in1_ready, 1'b1);
        tick();
        chk("mid_pending_write", bus.rf_write, 1'b1);
        chk("mid_pending_waddr", bus.rf_waddr, 5'd6);
        set1(1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        #1;
        chk("mid_rst_write", bus.rf_write, 1'b0);
        chk("mid_rst_cnt", bus.contention_cnt, 8'd0);
        reset = 1'b0;

        // Sustained contention after reset: p0,p1,p0,p1 with fresh data each grant
        d0 = 32'h30;
        d1 = 32'h70;
        set0(1'b1, 5'd3, d0);
        set1(1'b1, 5'd7, d1);
        exp_p1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", bus.in0_ready, !exp_p1);
            chk("rr_ready1", bus.in1_ready, exp_p1);
            tick();
            chk("rr_write", bus.rf_write, 1'b1);
            chk("rr_waddr", bus.rf_waddr, exp_p1 ? 5'd7 : 5'd3);
            chk("rr_wdata", bus.rf_wdata, exp_p1 ? d1 : d0);
            if (exp_p1) begin
                d1 = d1 + 32'h1;
                set1(1'b1, 5'd7, d1);
            end else begin
                d0 = d0 + 32'h1;
                set0(1'b1, 5'd3, d0);
            end
            exp_p1 = !exp_p1;
        end
        chk("rr_cnt", bus.contention_cnt, 8'd4);

        // Saturation: 251 more contended cycles reach 255, further cycles hold
        for (int i = 0; i < 251; i++) tick();
        chk("sat_reach", bus.contention_cnt, 8'hFF);
        for (int i = 0; i < 9; i++) tick();
        chk("sat_hold", bus.contention_cnt, 8'hFF);

        set0(1'b0, 5'd0, 32'h0);
        set1(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        chk("end_idle_write", bus.rf_write, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
